inst_sram: RTL and testbench

INST_SRAM -- requirements
Module: inst_sram

---
 rtl/npc_mem_pkg.sv | 7 +
 rtl/inst_sram_if.sv | 12 +
 rtl/isram_array.sv | 17 +
 rtl/inst_sram.sv | 64 ++++++
 tb/tb_inst_sram.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/npc_mem_pkg.sv
// npc_mem_pkg: shared fetch-bus FSM states, response codes and memory base address
package npc_mem_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [31:0] BASE_DEFAULT = 32'h8000_0000;
endpackage

// File: rtl/inst_sram_if.sv
// inst_sram_if: AR/R fetch channel between the IFU (master) and the instruction SRAM (slave)
interface inst_sram_if;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    modport master (output arvalid, araddr, rready, input arready, rvalid, rdata, rresp);
    modport slave  (input arvalid, araddr, rready, output arready, rvalid, rdata, rresp);
endinterface

// File: rtl/isram_array.sv
// isram_array: instruction word array with a preload write port and a combinational read port
module isram_array #(
    parameter int DEPTH = 1024,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_widx,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_ridx,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [DEPTH];
    always_ff @(posedge clk)
        if (i_we) r_mem[i_widx] <= i_wdata;
    assign o_rdata = r_mem[i_ridx];
endmodule

// File: rtl/inst_sram.sv
// inst_sram: fixed-latency instruction SRAM slave with address checking and a preload port
module inst_sram import npc_mem_pkg::*; #(
    parameter int DEPTH = 1024,
    parameter logic [31:0] BASE = BASE_DEFAULT,
    parameter int LAT = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    inst_sram_if.slave    bus,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_idx,
    input  logic [31:0]   ld_data
);
    localparam logic [32:0] SPAN = 33'(4 * DEPTH);
    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    logic [31:0] w_off;
    logic [31:0] w_mem;
    logic        w_legal;
    assign w_off = r_addr - BASE;
    assign w_legal = (r_addr[1:0] == 2'b00) && (r_addr >= BASE) && ({1'b0, w_off} < SPAN);
    // The array read is combinational, so a preload on the latch edge is seen only afterwards.
    isram_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clk     (clk),
        .i_we    (ld_en),
        .i_widx  (ld_idx),
        .i_wdata (ld_data),
        .i_ridx  (w_off[AW+1:2]),
        .o_rdata (w_mem)
    );
    assign bus.arready = (r_state == IDLE);
    assign bus.rvalid  = (r_state == RESP);
    assign bus.rdata   = r_rdata;
    assign bus.rresp   = r_rresp;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else if (r_state == IDLE && bus.arvalid) begin
            r_addr  <= bus.araddr;
            r_cnt   <= 4'(LAT - 1);
            r_state <= BUSY;
        end else if (r_state == BUSY) begin
            if (r_cnt == 4'd0) begin
                r_state <= RESP;
                r_rdata <= w_legal ? w_mem : 32'd0;
                r_rresp <= w_legal ? RESP_OKAY : RESP_SLVERR;
            end else begin
                r_cnt <= r_cnt - 4'd1;
            end
        end else if (r_state == RESP && bus.rready) begin
            r_state <= IDLE;
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end
    end
endmodule

// File: tb/tb_inst_sram.sv
// tb_inst_sram: scoreboard-driven bench for inst_sram at LAT=2 (dut_a) and LAT=1 (dut_b)
module tb_inst_sram;
    import npc_mem_pkg::*;
    typedef struct {logic [31:0] d; logic [1:0] r;} exp_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    inst_sram_if ia();
    inst_sram_if ib();
    logic        ld_en_a = 1'b0, ld_en_b = 1'b0;
    logic [9:0]  ld_idx_a = '0, ld_idx_b = '0;
    logic [31:0] ld_data_a = '0, ld_data_b = '0;
    exp_t sb[$];
    int n_pass = 0;
    int n_total = 0;

    inst_sram #(.DEPTH(1024), .LAT(2)) dut_a (
        .clk(clk), .rst(rst), .bus(ia), .ld_en(ld_en_a), .ld_idx(ld_idx_a), .ld_data(ld_data_a));
    inst_sram #(.DEPTH(1024), .LAT(1)) dut_b (
        .clk(clk), .rst(rst), .bus(ib), .ld_en(ld_en_b), .ld_idx(ld_idx_b), .ld_data(ld_data_b));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input int idx, input logic [31:0] d);
        ld_idx_a = idx[9:0]; ld_data_a = d; ld_en_a = 1'b1;
        tick();
        ld_en_a = 1'b0;
    endtask

    task automatic load_b(input int idx, input logic [31:0] d);
        ld_idx_b = idx[9:0]; ld_data_b = d; ld_en_b = 1'b1;
        tick();
        ld_en_b = 1'b0;
    endtask

    task automatic fetch_a(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r, output int lat);
        ia.araddr = a; ia.arvalid = 1'b1; ia.rready = 1'b0;
        tick();
        ia.arvalid = 1'b0;
        lat = 0;
        while (!ia.rvalid && lat < 20) begin
            tick();
            lat++;
        end
        d = ia.rdata;
        r = ia.rresp;
    endtask

    task automatic release_a;
        ia.rready = 1'b1;
        tick();
        ia.rready = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        n_total++; if (ia.arready !== 1'b1) $display("FAIL reset_arready got %b want 1", ia.arready); else n_pass++;
        n_total++; if (ia.rvalid !== 1'b0) $display("FAIL reset_rvalid got %b want 0", ia.rvalid); else n_pass++;
        n_total++; if (ia.rdata !== 32'd0) $display("FAIL reset_rdata got %h want 0", ia.rdata); else n_pass++;
        n_total++; if (ia.rresp !== RESP_OKAY) $display("FAIL reset_rresp got %b want 00", ia.rresp); else n_pass++;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        exp_t e; logic [31:0] d; logic [1:0] r; int lat;
        load_a(0, 32'h0000_0413);
        sb.push_back('{32'h0000_0413, RESP_OKAY});
        fetch_a(32'h8000_0000, d, r, lat);
        e = sb.pop_front();
        n_total++; if (lat !== 2) $display("FAIL basic_latency got %0d want 2", lat); else n_pass++;
        n_total++; if (d !== e.d) $display("FAIL basic_rdata got %h want %h", d, e.d); else n_pass++;
        n_total++; if (r !== e.r) $display("FAIL basic_rresp got %b want %b", r, e.r); else n_pass++;
        release_a();
    endtask

    task automatic test_backpressure;
        exp_t e; logic [31:0] d; logic [1:0] r; int lat;
        load_a(5, 32'hDEAD_BEEF);
        sb.push_back('{32'hDEAD_BEEF, RESP_OKAY});
        fetch_a(32'h8000_0014, d, r, lat);
        e = sb.pop_front();
        n_total++; if (d !== e.d) $display("FAIL bp_rdata got %h want %h", d, e.d); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++; if (ia.rvalid !== 1'b1) $display("FAIL bp_hold_rvalid cycle %0d got %b want 1", i, ia.rvalid); else n_pass++;
            n_total++; if (ia.rdata !== e.d) $display("FAIL bp_hold_rdata cycle %0d got %h want %h", i, ia.rdata, e.d); else n_pass++;
        end
        ia.rready = 1'b1;
        tick();
        ia.rready = 1'b0;
        n_total++; if (ia.arready !== 1'b1) $display("FAIL bp_arready_after got %b want 1", ia.arready); else n_pass++;
        n_total++; if (ia.rvalid !== 1'b0) $display("FAIL bp_rvalid_after got %b want 0", ia.rvalid); else n_pass++;
        n_total++; if (ia.rdata !== 32'd0) $display("FAIL bp_rdata_idle got %h want 0", ia.rdata); else n_pass++;
    endtask

    task automatic test_errors;
        logic [31:0] addrs [4];
        exp_t e; logic [31:0] d; logic [1:0] r; int lat;
        addrs = '{32'h8000_0002, 32'h8000_1000, 32'h7FFF_FFFC, 32'h8000_0FFC};
        load_a(1023, 32'hCAFE_F00D);
        sb.push_back('{32'd0, RESP_SLVERR});
        sb.push_back('{32'd0, RESP_SLVERR});
        sb.push_back('{32'd0, RESP_SLVERR});
        sb.push_back('{32'hCAFE_F00D, RESP_OKAY});
        for (int i = 0; i < 4; i++) begin
            fetch_a(addrs[i], d, r, lat);
            e = sb.pop_front();
            n_total++; if (lat !== 2) $display("FAIL err_latency %h got %0d want 2", addrs[i], lat); else n_pass++;
            n_total++; if (r !== e.r) $display("FAIL err_rresp %h got %b want %b", addrs[i], r, e.r); else n_pass++;
            n_total++; if (d !== e.d) $display("FAIL err_rdata %h got %h want %h", addrs[i], d, e.d); else n_pass++;
            release_a();
        end
    endtask

    task automatic test_collision;
        exp_t e; logic [31:0] d; logic [1:0] r; int lat;
        load_a(3, 32'hAAAA_0001);
        sb.push_back('{32'hAAAA_0001, RESP_OKAY});
        ia.araddr = 32'h8000_000C; ia.arvalid = 1'b1;
        tick();
        ia.arvalid = 1'b0;
        tick();
        ld_idx_a = 10'd3; ld_data_a = 32'hBBBB_0002; ld_en_a = 1'b1;
        tick();
        ld_en_a = 1'b0;
        e = sb.pop_front();
        n_total++; if (ia.rvalid !== 1'b1) $display("FAIL coll_rvalid got %b want 1", ia.rvalid); else n_pass++;
        n_total++; if (ia.rdata !== e.d) $display("FAIL coll_old_word got %h want %h", ia.rdata, e.d); else n_pass++;
        release_a();
        sb.push_back('{32'hBBBB_0002, RESP_OKAY});
        fetch_a(32'h8000_000C, d, r, lat);
        e = sb.pop_front();
        n_total++; if (d !== e.d) $display("FAIL coll_new_word got %h want %h", d, e.d); else n_pass++;
        release_a();
    endtask

    task automatic test_reset_mid;
        exp_t e; logic [31:0] d; logic [1:0] r; int lat; int seen;
        load_a(7, 32'h1234_5678);
        ia.araddr = 32'h8000_001C; ia.arvalid = 1'b1;
        tick();
        ia.arvalid = 1'b0;
        n_total++; if (ia.arready !== 1'b0) $display("FAIL rstmid_busy_arready got %b want 0", ia.arready); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_total++; if (ia.rvalid !== 1'b0) $display("FAIL rstmid_rvalid got %b want 0", ia.rvalid); else n_pass++;
        n_total++; if (ia.arready !== 1'b1) $display("FAIL rstmid_arready got %b want 1", ia.arready); else n_pass++;
        tick();
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ia.rvalid) seen++;
        end
        n_total++; if (seen !== 0) $display("FAIL rstmid_no_resp got %0d responses want 0", seen); else n_pass++;
        sb.push_back('{32'h1234_5678, RESP_OKAY});
        fetch_a(32'h8000_001C, d, r, lat);
        e = sb.pop_front();
        n_total++; if (d !== e.d) $display("FAIL rstmid_mem_kept got %h want %h", d, e.d); else n_pass++;
        release_a();
    endtask

    task automatic test_back_to_back;
        exp_t e; int cyc; int got; int t [3];
        t = '{0, 0, 0};
        load_b(0, 32'h1111_1111);
        load_b(1, 32'h2222_2222);
        load_b(2, 32'h3333_3333);
        sb.push_back('{32'h1111_1111, RESP_OKAY});
        sb.push_back('{32'h2222_2222, RESP_OKAY});
        sb.push_back('{32'h3333_3333, RESP_OKAY});
        ib.rready = 1'b1; ib.araddr = 32'h8000_0000; ib.arvalid = 1'b1;
        cyc = 0; got = 0;
        while (got < 3 && cyc < 40) begin
            tick();
            cyc++;
            if (ib.rvalid) begin
                e = sb.pop_front();
                n_total++; if (ib.rdata !== e.d) $display("FAIL b2b_rdata %0d got %h want %h", got, ib.rdata, e.d); else n_pass++;
                t[got] = cyc;
                got++;
                ib.araddr = 32'h8000_0000 + 32'(4 * got);
                if (got == 3) ib.arvalid = 1'b0;
            end
        end
        tick();
        ib.rready = 1'b0;
        n_total++; if (got !== 3) $display("FAIL b2b_count got %0d want 3", got); else n_pass++;
        n_total++; if (t[0] !== 2) $display("FAIL b2b_first_cycle got %0d want 2", t[0]); else n_pass++;
        n_total++; if (t[1] - t[0] !== 3) $display("FAIL b2b_spacing1 got %0d want 3", t[1] - t[0]); else n_pass++;
        n_total++; if (t[2] - t[1] !== 3) $display("FAIL b2b_spacing2 got %0d want 3", t[2] - t[1]); else n_pass++;
    endtask

    initial begin
        ia.arvalid = 1'b0; ia.araddr = '0; ia.rready = 1'b0;
        ib.arvalid = 1'b0; ib.araddr = '0; ib.rready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_errors();
        test_collision();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
